// File: rtl/exec_pkg.sv
// Shared definitions for the execution cluster: ALU mode encodings and
// default operand/tag widths.
package exec_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int IDX_W_DEF  = 6;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_mode_e;

endpackage

// File: rtl/exec_mult_pipe.sv
// Multiplier pipeline with writeback backpressure, tag tracking and flush.
// The product is formed on entry and carried through the stages with its tag.
module exec_mult_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MULT_LAT = 3,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mult_en,
  input  logic [DATA_W-1:0] mult_op1,
  input  logic [DATA_W-1:0] mult_op2,
  input  logic [IDX_W-1:0]  mult_indx,
  input  logic              mult_wb_rdy,
  output logic [DATA_W-1:0] mult_out,
  output logic [IDX_W-1:0]  mult_indx_out,
  output logic              mult_valid_wb,
  output logic              reg_wrt_mul,
  output logic              mult_free
);

  logic [MULT_LAT-1:0] vld;
  logic [DATA_W-1:0]   dat [MULT_LAT];
  logic [IDX_W-1:0]    tag [MULT_LAT];
  logic [DATA_W-1:0]   prod;
  logic                stall;
  logic                issue;

  // Low DATA_W bits of the product are identical for signed and unsigned.
  assign prod  = mult_op1 * mult_op2;

  assign stall     = vld[MULT_LAT-1] & ~mult_wb_rdy;
  assign mult_free = ~stall;
  assign issue     = mult_en & mult_free & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int s = 0; s < MULT_LAT; s++) begin
        dat[s] <= '0;
        tag[s] <= '0;
      end
    end else begin
      // Flush wins over a stalled head so recovery never waits on writeback.
      if (flush) begin
        vld <= '0;
      end else if (!stall) begin
        vld <= {vld[MULT_LAT-2:0], issue};
      end
      if (!stall) begin
        dat[0] <= prod;
        tag[0] <= mult_indx;
        for (int s = 1; s < MULT_LAT; s++) begin
          dat[s] <= dat[s-1];
          tag[s] <= tag[s-1];
        end
      end
    end
  end

  assign mult_out      = dat[MULT_LAT-1];
  assign mult_indx_out = tag[MULT_LAT-1];
  assign mult_valid_wb = vld[MULT_LAT-1];
  assign reg_wrt_mul   = vld[MULT_LAT-1] & mult_wb_rdy;

endmodule

// File: rtl/exec_cluster.sv
// Execution cluster: NUM_ALU single-cycle ALU lanes, an address adder and a
// stallable multiplier pipeline, all sharing one flush.
module exec_cluster
  import exec_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_ALU  = 2,
  parameter int MULT_LAT = 3,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_ALU-1:0]        alu_en,
  input  logic [NUM_ALU*DATA_W-1:0] alu_op1,
  input  logic [NUM_ALU*DATA_W-1:0] alu_op2,
  input  logic [NUM_ALU*3-1:0]      alu_mode,
  input  logic [NUM_ALU-1:0]        alu_inv_Rt,
  input  logic [NUM_ALU*IDX_W-1:0]  alu_indx,
  output logic [NUM_ALU*DATA_W-1:0] alu_out,
  output logic [NUM_ALU*IDX_W-1:0]  alu_indx_out,
  output logic [NUM_ALU-1:0]        alu_valid,
  input  logic                      mult_en,
  input  logic [DATA_W-1:0]         mult_op1,
  input  logic [DATA_W-1:0]         mult_op2,
  input  logic [IDX_W-1:0]          mult_indx,
  input  logic                      mult_wb_rdy,
  output logic [DATA_W-1:0]         mult_out,
  output logic [IDX_W-1:0]          mult_indx_out,
  output logic                      mult_valid_wb,
  output logic                      reg_wrt_mul,
  output logic                      mult_free,
  input  logic                      addr_en,
  input  logic [DATA_W-1:0]         addr_op1,
  input  logic [DATA_W-1:0]         addr_op2,
  input  logic [IDX_W-1:0]          addr_indx,
  output logic [DATA_W-1:0]         addr_out,
  output logic [IDX_W-1:0]          addr_indx_out,
  output logic                      addr_valid
);

  localparam int SH_W = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [2:0]        mode,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] r;
    sh = b[SH_W-1:0];
    r  = '0;
    case (alu_mode_e'(mode))
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << sh;
      ALU_SRL: r = a >> sh;
      ALU_SRA: r = $unsigned($signed(a) >>> sh);
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] res_d [NUM_ALU];
  logic [DATA_W-1:0] res_q [NUM_ALU];
  logic [IDX_W-1:0]  tag_q [NUM_ALU];

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_lane
    logic [DATA_W-1:0] op2_eff;
    assign op2_eff  = alu_inv_Rt[i] ? ~alu_op2[i*DATA_W +: DATA_W]
                                    :  alu_op2[i*DATA_W +: DATA_W];
    assign res_d[i] = alu_calc(alu_mode[i*3 +: 3], alu_op1[i*DATA_W +: DATA_W], op2_eff);
    assign alu_out[i*DATA_W +: DATA_W]     = res_q[i];
    assign alu_indx_out[i*IDX_W +: IDX_W]  = tag_q[i];
  end

  // Result/tag registers load on issue even under flush; only valid is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_valid <= '0;
      for (int i = 0; i < NUM_ALU; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      alu_valid <= alu_en & {NUM_ALU{~flush}};
      for (int i = 0; i < NUM_ALU; i++) begin
        if (alu_en[i]) begin
          res_q[i] <= res_d[i];
          tag_q[i] <= alu_indx[i*IDX_W +: IDX_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_valid    <= 1'b0;
      addr_out      <= '0;
      addr_indx_out <= '0;
    end else begin
      addr_valid <= addr_en & ~flush;
      if (addr_en) begin
        addr_out      <= addr_op1 + addr_op2;
        addr_indx_out <= addr_indx;
      end
    end
  end

  exec_mult_pipe #(
    .DATA_W   (DATA_W),
    .MULT_LAT (MULT_LAT),
    .IDX_W    (IDX_W)
  ) u_mult (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .mult_en       (mult_en),
    .mult_op1      (mult_op1),
    .mult_op2      (mult_op2),
    .mult_indx     (mult_indx),
    .mult_wb_rdy   (mult_wb_rdy),
    .mult_out      (mult_out),
    .mult_indx_out (mult_indx_out),
    .mult_valid_wb (mult_valid_wb),
    .reg_wrt_mul   (reg_wrt_mul),
    .mult_free     (mult_free)
  );

endmodule

// File: doc/exec_cluster.md
EXEC_CLUSTER -- requirements
Module: exec_cluster

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width.
REQ-002 Parameter NUM_ALU, default 2, number of ALU lanes (1..4).
REQ-003 Parameter MULT_LAT, default 3, multiplier pipeline depth in cycles (2..6).
REQ-004 Parameter IDX_W, default 6, reorder-index tag width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  kill all in-flight operations (mispredict recovery).
REQ-008 alu_en  in  NUM_ALU  per-lane issue strobe.
REQ-009 alu_op1, alu_op2  in  NUM_ALU*DATA_W  packed per-lane operands.
REQ-010 alu_mode  in  NUM_ALU*3  packed per-lane operation select.
REQ-011 alu_inv_Rt  in  NUM_ALU  per-lane invert-op2 control.
REQ-012 alu_indx  in  NUM_ALU*IDX_W  per-lane tag.
REQ-013 alu_out, alu_indx_out, alu_valid  out  packed per lane  registered result, tag, valid.
REQ-014 mult_en, mult_op1, mult_op2, mult_indx  in  1/DATA_W/DATA_W/IDX_W  multiplier issue.
REQ-015 mult_wb_rdy  in  1  writeback port accepts multiplier result this cycle.
REQ-016 mult_out, mult_indx_out, mult_valid_wb, reg_wrt_mul, mult_free  out  DATA_W/IDX_W/1/1/1.
REQ-017 addr_en, addr_op1, addr_op2, addr_indx  in  1/DATA_W/DATA_W/IDX_W  address-generation issue.
REQ-018 addr_out, addr_indx_out, addr_valid  out  DATA_W/IDX_W/1.

Function
REQ-019 ALU lane: one-cycle latency; op2' = alu_inv_Rt ? ~op2 : op2; modes 000 ADD, 001 SUB (op1-op2'), 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA; shift amount = op2'[3:0] (low log2(DATA_W) bits).
REQ-020 ALU arithmetic modulo 2^DATA_W, carry/overflow discarded.
REQ-021 alu_valid[i] next = alu_en[i] & ~flush; alu_out/alu_indx_out load only when alu_en[i], otherwise hold.
REQ-022 Address adder: one-cycle latency, addr_out = addr_op1 + addr_op2 mod 2^DATA_W; addr_valid next = addr_en & ~flush.
REQ-023 Multiplier: product = low DATA_W bits of op1*op2 (signed and unsigned identical); result appears MULT_LAT cycles after accepted issue when no stall.
REQ-024 Multiplier stages each carry valid, tag, partial data; last stage drives mult_out, mult_indx_out, mult_valid_wb.
REQ-025 Stall = mult_valid_wb & ~mult_wb_rdy; during stall all stages hold.
REQ-026 mult_free = ~stall (combinational); issue accepted only when mult_en & mult_free; mult_en while ~mult_free is ignored (issuer must hold).
REQ-027 Result retires on cycle mult_valid_wb & mult_wb_rdy; simultaneous retire and new issue both succeed, throughput one per cycle.
REQ-028 reg_wrt_mul = mult_valid_wb & mult_wb_rdy.
REQ-029 flush: next cycle all valid bits (ALU, address, every multiplier stage) are 0; same-cycle issues discarded; flush overrides stall.
REQ-030 Data/tag registers need not clear on flush; only valids are authoritative.

Reset
REQ-031 While rst low: all valid outputs 0, mult_free 1, all data/tag outputs 0.
REQ-032 Reset asserted mid-operation discards in-flight multiplier ops; no result emitted after release.
REQ-033 First issue accepted on first rising edge after rst deasserts.

Structure
REQ-034 Package exec_pkg holds ALU mode encodings and default DATA_W/IDX_W constants.
REQ-035 Sub-module exec_mult_pipe implements REQ-023..REQ-028 (stall, tags, flush); ALU lanes via generate loop in top.

Verification
REQ-036 Lane0 ADD 0x7FFF+0x0001, lane1 SUB 5-7, tags 3/4 -> next cycle 0x8000 tag3, 0xFFFE tag4, both valid.
REQ-037 mult 0x0100*0x0100 tag 9, rdy=1, MULT_LAT=3 -> mult_out 0x0000, tag 9, valid exactly 3 cycles later, reg_wrt_mul 1.
REQ-038 Back-to-back mults 3*4, 5*6, 7*8 with rdy held low from cycle 3 for 2 cycles -> mult_free 0 two cycles, results 12,30,56 in order, none lost/duplicated.
REQ-039 Issue two mults then flush next cycle -> no mult_valid_wb ever; mult_free 1 cycle after flush.
REQ-040 ALU SRA 0x8000 by 4 with alu_inv_Rt=0 -> 0xF800; AND 0x00FF with op2 0x0F0F, inv_Rt=1 -> 0x00F0.
REQ-041 rst low for one cycle while multiplier holds 2 ops -> all outputs 0, no results emerge afterwards.
